// File: rtl/shiftregout_pkg.sv
// Shared definitions for the result shift-out bank: default sizes and FSM state encoding.
package shiftregout_pkg;
    localparam int N_DSP  = 40;
    localparam int ADDR_W = 6;
    localparam int B_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;
endpackage

// File: rtl/shiftregout_regunitout.sv
// One bank word: parallel capture has priority over shifting in the higher neighbour's word.
module regunitout #(
    parameter int B = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic         sh,
    input  logic [B-1:0] d,
    input  logic [B-1:0] sh_in,
    output logic [B-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (ld) q <= d;
        else if (sh) q <= sh_in;
    end
endmodule

// File: rtl/shiftregout.sv
// Captures N result words in one cycle, then streams them out in unit order or serves addressed reads.
module shiftregout
    import shiftregout_pkg::*;
#(
    parameter int B = B_DEF,
    parameter int N = N_DSP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*B-1:0]    in,
    input  logic              load,
    input  logic              mode,
    input  logic              out_ready,
    output logic [B-1:0]      out,
    output logic              out_valid,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    output logic [B-1:0]      rd_data,
    output logic              rd_valid,
    output logic              rd_err,
    input  logic              clear,
    output logic              busy,
    output logic              done,
    output logic              ovf
);
    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [B-1:0]        bank [N];
    logic [B-1:0]        rd_word;
    logic                hs, last, load_ok;

    assign out       = bank[0];
    assign out_valid = (state == ST_STREAM);
    assign busy      = (state != ST_IDLE);
    assign hs        = out_valid & out_ready;
    assign last      = (cnt == ADDR_W'(N - 1));
    // A capture is taken in IDLE, or on the very cycle the final stream word leaves.
    assign load_ok   = load & ((state == ST_IDLE) | (hs & last));

    for (genvar gi = 0; gi < N; gi++) begin : g_bank
        logic [B-1:0] sh_in;
        if (gi == N - 1) begin : g_top
            assign sh_in = '0;
        end else begin : g_mid
            assign sh_in = bank[gi+1];
        end
        regunitout #(.B(B)) u_word (
            .clk   (clk),
            .rst_n (rst_n),
            .ld    (load_ok),
            .sh    (hs),
            .d     (in[gi*B +: B]),
            .sh_in (sh_in),
            .q     (bank[gi])
        );
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N; i++)
            if (addr == ADDR_W'(i)) rd_word = bank[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            ovf      <= load & ~load_ok & busy;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        cnt   <= '0;
                        state <= mode ? ST_HOLD : ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (out_ready) begin
                        if (last) begin
                            done  <= 1'b1;
                            cnt   <= '0;
                            if (load) state <= mode ? ST_HOLD : ST_STREAM;
                            else      state <= ST_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (rd_en) begin
                        rd_valid <= 1'b1;
                        rd_data  <= rd_word;
                        rd_err   <= (32'(addr) >= 32'(N));
                    end
                    if (clear) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
